// File: rtl/linear_upsampler_pkg.sv
// Shared types and helpers for the linear interpolating upsampler.
package linear_upsampler_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PRIMED = 2'd1,
        RUN    = 2'd2
    } state_t;

    function automatic int calc_shift(input int upsample);
        return $clog2(upsample);
    endfunction

endpackage

// File: rtl/linear_upsampler.sv
// Linear interpolating upsampler: UPSAMPLE outputs per input interval, floor rounded.
// Optional macro LINEAR_UPSAMPLER_ZOH_EN adds zoh_sel (zero-order hold instead of ramp).
module linear_upsampler
    import linear_upsampler_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int UPSAMPLE   = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic signed [DATA_WIDTH-1:0]                     in_data,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    output logic signed [DATA_WIDTH-1:0]                     out_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
`ifdef LINEAR_UPSAMPLER_ZOH_EN
    input  logic                                             zoh_sel,
`endif
    output logic [1:0]                                       o_dbg_state,
    output logic [DATA_WIDTH+calc_shift(UPSAMPLE):0]         o_dbg_acc
);

    localparam int SHIFT = calc_shift(UPSAMPLE);
    localparam int AW    = DATA_WIDTH + SHIFT + 1;
    localparam int DW1   = DATA_WIDTH + 1;
    localparam logic [SHIFT-1:0] LAST_PHASE = SHIFT'(UPSAMPLE - 1);

    // Handshake: out_valid/in_ready are the producer/consumer qualifiers;
    // a transfer happens only in a cycle where valid and ready are both high.
    state_t                       r_state;
    logic signed [AW-1:0]         r_acc;
    logic        [SHIFT-1:0]      r_phase;
    logic signed [DATA_WIDTH-1:0] r_prev;
    logic signed [DATA_WIDTH-1:0] r_next;
    logic signed [DW1-1:0]        r_delta;

    state_t                       w_state_nxt;
    logic signed [AW-1:0]         w_acc_nxt;
    logic        [SHIFT-1:0]      w_phase_nxt;
    logic signed [DATA_WIDTH-1:0] w_prev_nxt;
    logic signed [DATA_WIDTH-1:0] w_next_nxt;
    logic signed [DW1-1:0]        w_delta_nxt;

    logic                         w_in_fire;
    logic                         w_out_fire;
    logic                         w_last;
    logic                         w_zoh;
    logic signed [DW1-1:0]        w_in_ext;
    logic signed [DW1-1:0]        w_base_ext;
    logic signed [DW1-1:0]        w_delta_in;
    logic signed [AW-1:0]         w_in_wide;
    logic signed [AW-1:0]         w_next_wide;

`ifdef LINEAR_UPSAMPLER_ZOH_EN
    assign w_zoh = zoh_sel;
`else
    assign w_zoh = 1'b0;
`endif

    assign w_last     = (r_phase == LAST_PHASE);
    assign out_valid  = (r_state == RUN);
    assign in_ready   = (r_state != RUN) || (w_last && out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Floor rounding falls out of the arithmetic shift; no extra logic.
    assign out_data    = r_acc[DATA_WIDTH+SHIFT-1:SHIFT];
    assign o_dbg_state = r_state;
    assign o_dbg_acc   = r_acc;

    // The new interval starts from prev in PRIMED and from next at a RUN wrap.
    assign w_in_ext    = DW1'(in_data);
    assign w_base_ext  = (r_state == RUN) ? DW1'(r_next) : DW1'(r_prev);
    assign w_delta_in  = w_zoh ? '0 : (w_in_ext - w_base_ext);
    assign w_in_wide   = AW'(in_data) <<< SHIFT;
    assign w_next_wide = AW'(r_next) <<< SHIFT;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_phase_nxt = r_phase;
        w_prev_nxt  = r_prev;
        w_next_nxt  = r_next;
        w_delta_nxt = r_delta;
        unique case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_prev_nxt  = in_data;
                    w_acc_nxt   = w_in_wide;
                    w_state_nxt = PRIMED;
                end
            end
            PRIMED: begin
                if (w_in_fire) begin
                    w_next_nxt  = in_data;
                    w_delta_nxt = w_delta_in;
                    w_phase_nxt = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_out_fire) begin
                    if (!w_last) begin
                        w_acc_nxt   = r_acc + AW'(r_delta);
                        w_phase_nxt = r_phase + SHIFT'(1);
                    end else begin
                        w_prev_nxt = r_next;
                        w_acc_nxt  = w_next_wide;
                        if (w_in_fire) begin
                            w_next_nxt  = in_data;
                            w_delta_nxt = w_delta_in;
                            w_phase_nxt = '0;
                        end else begin
                            w_state_nxt = PRIMED;
                        end
                    end
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_acc   <= '0;
            r_phase <= '0;
            r_prev  <= '0;
            r_next  <= '0;
            r_delta <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_phase <= w_phase_nxt;
            r_prev  <= w_prev_nxt;
            r_next  <= w_next_nxt;
            r_delta <= w_delta_nxt;
        end
    end

endmodule

// File: tb/tb_linear_upsampler.sv
// Directed bench for linear_upsampler (DATA_WIDTH=12, UPSAMPLE=4).
module tb_linear_upsampler;
    import linear_upsampler_pkg::*;

    logic               clk;
    logic               rst_n;
    logic signed [11:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] out_data;
    logic               out_valid;
    logic               out_ready;
`ifdef LINEAR_UPSAMPLER_ZOH_EN
    logic               zoh_sel;
`endif
    logic [1:0]         dbg_state;
    logic [14:0]        dbg_acc;

    int vectors;
    int miscompares;

    linear_upsampler #(.DATA_WIDTH(12), .UPSAMPLE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef LINEAR_UPSAMPLER_ZOH_EN
        .zoh_sel     (zoh_sel),
`endif
        .o_dbg_state (dbg_state),
        .o_dbg_acc   (dbg_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // Present one input while the block is idle/primed; it must be accepted.
    task automatic feed(input string tag, input logic signed [11:0] d);
        in_valid = 1'b1;
        in_data  = d;
        check(tag, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Check one output beat, then let it transfer.
    task automatic expect_out(input string tag, input logic signed [31:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_data"}, 32'(out_data), exp);
        tick();
    endtask

    int exp_bb[8];

    initial begin
        vectors     = 0;
        miscompares = 0;
        out_ready   = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
`ifdef LINEAR_UPSAMPLER_ZOH_EN
        zoh_sel     = 1'b0;
`endif
        rst_n       = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_state", 32'(dbg_state), 32'(EMPTY));
        check("rst_acc", 32'(dbg_acc), 0);
        rst_n = 1'b1;

        // Ramp 0 -> 100
        feed("ramp_in0", 12'sd0);
        check("ramp_primed_state", 32'(dbg_state), 32'(PRIMED));
        check("ramp_primed_valid", 32'(out_valid), 0);
        feed("ramp_in1", 12'sd100);
        expect_out("ramp_k0", 0);
        expect_out("ramp_k1", 25);
        expect_out("ramp_k2", 50);
        check("ramp_last_in_ready", 32'(in_ready), 1);
        expect_out("ramp_k3", 75);
        check("ramp_end_valid", 32'(out_valid), 0);
        check("ramp_end_state", 32'(dbg_state), 32'(PRIMED));

        // Back-to-back 0 -> 100 -> -100 with input held valid
        do_reset();
        exp_bb = '{0, 25, 50, 75, 100, 50, 0, -50};
        feed("bb_in0", 12'sd0);
        feed("bb_in1", 12'sd100);
        in_valid = 1'b1;
        in_data  = -12'sd100;
        for (int k = 0; k < 8; k++) begin
            if (k < 3) check("bb_in_ready_low", 32'(in_ready), 0);
            if (k == 3) check("bb_in_ready_cycle4", 32'(in_ready), 1);
            expect_out($sformatf("bb_k%0d", k), exp_bb[k]);
            if (k == 3) in_valid = 1'b0;
        end
        check("bb_end_valid", 32'(out_valid), 0);

        // Negative floor 0 -> -3
        do_reset();
        feed("neg_in0", 12'sd0);
        feed("neg_in1", -12'sd3);
        expect_out("neg_k0", 0);
        expect_out("neg_k1", -1);
        expect_out("neg_k2", -2);
        expect_out("neg_k3", -3);

        // Full-scale swing +max -> min
        do_reset();
        feed("ext_in0", 12'sd2047);
        feed("ext_in1", -12'sd2048);
        expect_out("ext_k0", 2047);
        expect_out("ext_k1", 1023);
        expect_out("ext_k2", -1);
        expect_out("ext_k3", -1025);

        // Backpressure at phase 2
        do_reset();
        feed("bp_in0", 12'sd0);
        feed("bp_in1", 12'sd100);
        expect_out("bp_k0", 0);
        expect_out("bp_k1", 25);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 12'sd7;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_data", 32'(out_data), 50);
            check("bp_hold_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        expect_out("bp_k2", 50);
        expect_out("bp_k3", 75);
        check("bp_end_valid", 32'(out_valid), 0);

        // Reset in the middle of an interval
        do_reset();
        feed("mr_in0", 12'sd0);
        feed("mr_in1", 12'sd100);
        expect_out("mr_k0", 0);
        check("mr_k1_data", 32'(out_data), 25);
        rst_n = 1'b0;
        tick();
        check("mr_rst_valid", 32'(out_valid), 0);
        check("mr_rst_data", 32'(out_data), 0);
        check("mr_rst_state", 32'(dbg_state), 32'(EMPTY));
        rst_n = 1'b1;
        feed("mr_first_in", 12'sd40);
        check("mr_first_state", 32'(dbg_state), 32'(PRIMED));
        check("mr_first_valid", 32'(out_valid), 0);
        tick();
        check("mr_idle_valid", 32'(out_valid), 0);

`ifdef LINEAR_UPSAMPLER_ZOH_EN
        // Zero-order hold 10 -> 90
        do_reset();
        zoh_sel = 1'b1;
        feed("zoh_in0", 12'sd10);
        feed("zoh_in1", 12'sd90);
        expect_out("zoh_k0", 10);
        expect_out("zoh_k1", 10);
        expect_out("zoh_k2", 10);
        expect_out("zoh_k3", 10);
        zoh_sel = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/linear_upsampler.md
Name: linear_upsampler

Overview:
- Interpolating upsampler: the expansion-side counterpart of the moving-average decimation/smoothing stage in the sample path.
- Accepts signed samples on a valid/ready input and emits UPSAMPLE linearly interpolated samples per input interval on a valid/ready output.
- Sits between low-rate sample processing and the higher-rate pixel/sample domain, on the same clock.

Parameters:
DATA_WIDTH, 12, signed sample width (input and output)
UPSAMPLE, 4, output samples per input interval; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous, active-low reset
in_data  in  DATA_WIDTH  signed input sample
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  DATA_WIDTH  signed interpolated sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n), as stated above. rst_n low at posedge forces state=EMPTY, acc=0, phase=0, prev=0, next=0, delta=0. Consequently out_valid=0 and out_data=0. Reset mid-RUN discards the interval in progress; no partial outputs follow.
- Constants: SHIFT = $clog2(UPSAMPLE). delta is signed DATA_WIDTH+1 bits. acc is signed DATA_WIDTH+SHIFT+1 bits. phase counter is SHIFT bits.
- out_data = acc >>> SHIFT, truncated to DATA_WIDTH. This is floor rounding, with no logic beyond the slice. out_valid = (state==RUN), driven directly from the state register.
- in_ready = (state!=RUN) || (phase==UPSAMPLE-1 && out_ready). This is a combinational path from out_ready and is required for back-to-back intervals.
- Fires: in_fire = in_valid&&in_ready; out_fire = out_valid&&out_ready.
- EMPTY (no history): on in_fire, prev<=in_data and acc<=in_data<<<SHIFT, then go to PRIMED.
- PRIMED (holding prev, waiting for next): on in_fire, next<=in_data, delta<=in_data-prev, phase<=0, then go to RUN.
- RUN, out_fire with phase<UPSAMPLE-1: acc<=acc+delta, phase<=phase+1.
- RUN, out_fire with phase==UPSAMPLE-1: prev<=next, acc<=next<<<SHIFT.
  - If in_fire in the same cycle: next<=in_data, delta<=in_data-next, phase<=0, stay in RUN.
  - Otherwise go to PRIMED.
- RUN without out_fire: all registers hold, so out_data is stable under backpressure.
- Output sequence per interval (a→b): floor((a*L + k*(b-a))/L) for k=0..L-1, where L = UPSAMPLE.
- Sample b is emitted as k=0 of the next interval.
- Latency: the first output is valid one cycle after the second input fires. Sustained throughput is 1 input per UPSAMPLE outputs with zero bubbles.
- Full-scale deltas (e.g. +max→min) must not overflow delta or acc.

Optional Feature:
- Macro: LINEAR_UPSAMPLER_ZOH_EN.
- Defined: adds input port zoh_sel (1 bit), sampled at every in_fire that enters or continues RUN. When zoh_sel=1, delta is forced to 0, giving a zero-order hold: the output repeats prev UPSAMPLE times.
- Undefined: the port is absent and interpolation is always linear.

Decomposition:
- Shared package holds state enum {EMPTY, PRIMED, RUN} and a SHIFT helper function (clog2 of UPSAMPLE).
- No sub-module; a single always_ff for state/datapath plus a combinational ready/valid assign.

Test Plan (DATA_WIDTH=12, UPSAMPLE=4 unless noted):
- Ramp: inputs 0, 100, out_ready=1 → outputs 0, 25, 50, 75; then out_valid=0 in PRIMED.
- Back-to-back: inputs 0, 100, -100 held valid → outputs 0, 25, 50, 75, 100, 50, 0, -50 with no bubble; in_ready is high on cycle 4.
- Negative floor: inputs 0, -3 → 0, -1, -2, -3. Extremes: inputs 2047, -2048 → 2047, 1023, -1, -1025.
- Backpressure: out_ready low for 5 cycles at phase 2 → out_data stays 50 and in_ready stays low; resume → sequence completes unchanged.
- Reset mid-RUN at phase 1 → out_valid=0 and out_data=0 on the next cycle; the next input is treated as the first (state PRIMED, no output).
- With LINEAR_UPSAMPLER_ZOH_EN: inputs 10, 90 with zoh_sel=1 → 10, 10, 10, 10.
